sr_latch_driver: RTL

Clocked front-end for the gated SR latch experiment. Turns two raw push-button inputs into clean, mutually exclusive, fixed-width set/reset strobes on the latch's set and reset pins. It synchronises, debounces and edge-detects each button, then runs a small strobe state machine. It sits directly upstream of the latch on the lab board, so the latch never sees bounce, overlap or a forbidden set+reset combination.

---
 rtl/sr_driver_pkg.sv | 20 ++
 rtl/button_debouncer.sv | 53 +++++
 rtl/sr_latch_driver.sv | 118 +++++++++++
 3 files changed

// File: rtl/sr_driver_pkg.sv
// Shared encodings and default parameter values for the SR latch front-end.
package sr_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } drv_state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_SET   = 2'd1,
    CMD_RESET = 2'd2
  } cmd_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_CYCLES    = 2;
  localparam int unsigned DEF_GAP_CYCLES      = 1;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability counter and registered rising-edge pulse
// for one raw push button.
module button_debouncer
  import sr_driver_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic          level_d;
  logic          rise_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      level_d <= 1'b0;
      rise_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= button;
      sync2   <= sync1;
      level_d <= level_q;
      rise_q  <= level_q & ~level_d;
      // Counter only runs while the input disagrees, so it never passes CNT_LAST.
      if (sync2 == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_q <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Debounced set/reset request arbitration producing fixed-width, mutually
// exclusive strobes for the gated SR latch.
module sr_latch_driver
  import sr_driver_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonSet,
  input  logic buttonReset,
  output logic latchSet,
  output logic latchReset,
  output logic busy,
  output logic dropped
);

  localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic req_set;
  logic req_reset;
  logic level_set;
  logic level_reset;

  drv_state_t    state, state_n;
  cmd_t          cmd, cmd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          drop_n;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clock  (clock),
    .reset  (reset),
    .button (buttonSet),
    .level  (level_set),
    .rise   (req_set)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clock  (clock),
    .reset  (reset),
    .button (buttonReset),
    .level  (level_reset),
    .rise   (req_reset)
  );

  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    cnt_n   = cnt;
    drop_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_set && req_reset) begin
          drop_n = 1'b1;
        end else if (req_set) begin
          cmd_n   = CMD_SET;
          state_n = ST_STROBE;
          cnt_n   = '0;
        end else if (req_reset) begin
          cmd_n   = CMD_RESET;
          state_n = ST_STROBE;
          cnt_n   = '0;
        end
      end
      ST_STROBE: begin
        drop_n = req_set | req_reset;
        if (cnt == PULSE_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        drop_n = req_set | req_reset;
        if (cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          cmd_n   = CMD_NONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cmd_n   = CMD_NONE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state so they change on the same edge as the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd        <= CMD_NONE;
      cnt        <= '0;
      latchSet   <= 1'b0;
      latchReset <= 1'b0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_n;
      cmd        <= cmd_n;
      cnt        <= cnt_n;
      latchSet   <= (state_n == ST_STROBE) && (cmd_n == CMD_SET);
      latchReset <= (state_n == ST_STROBE) && (cmd_n == CMD_RESET);
      busy       <= (state_n != ST_IDLE);
      dropped    <= drop_n;
    end
  end

endmodule
